// File: rtl/pipe_bundle_reg_if.sv
// Valid/ready bundle interface between a producing stage, pipe_bundle_reg and a consuming stage.
// The slave modport is the register's view; the master modport drives it from outside.
interface pipe_bundle_reg_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 64
);
    logic                      flush;
    logic [LANES-1:0]          kill_mask;
    logic [LANES-1:0]          in_valid;
    logic [LANES*DATA_W-1:0]   in_data;
    logic                      in_ready;
    logic [LANES-1:0]          out_valid;
    logic [LANES*DATA_W-1:0]   out_data;
    logic                      out_ready;
    logic [1:0]                occupancy;

    modport master (
        output flush, kill_mask, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, kill_mask, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_bundle_reg.sv
// Generic N-lane inter-stage pipeline register with a head + skid slot, registered in_ready,
// whole-stage flush and per-lane kill of the head bundle.
module pipe_bundle_reg #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    pipe_bundle_reg_if.slave   bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [LANES-1:0]          r_head_v;
    logic [LANES*DATA_W-1:0]   r_head_d;
    logic [LANES-1:0]          r_skid_v;
    logic [LANES*DATA_W-1:0]   r_skid_d;
    logic                      r_in_ready;

    logic                      w_accept;
    logic                      w_pop;
    logic [LANES-1:0]          w_head_kv;
    logic                      w_head_gone;

    assign w_accept    = r_in_ready & (|bus.in_valid);
    assign w_pop       = bus.out_ready & (|r_head_v);
    assign w_head_kv   = r_head_v & ~bus.kill_mask;
    // A head that is popped, or whose lanes are all killed, retires the same way.
    assign w_head_gone = w_pop | ~(|w_head_kv);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_EMPTY;
            r_head_v   <= '0;
            r_skid_v   <= '0;
            r_in_ready <= 1'b0;
        end else if (bus.flush) begin
            r_state    <= S_EMPTY;
            r_head_v   <= '0;
            r_skid_v   <= '0;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_head_v <= bus.in_valid;
                        r_head_d <= bus.in_data;
                        r_state  <= S_ONE;
                    end
                end
                S_ONE: begin
                    r_in_ready <= 1'b1;
                    if (w_head_gone) begin
                        if (w_accept) begin
                            r_head_v <= bus.in_valid;
                            r_head_d <= bus.in_data;
                        end else begin
                            r_head_v <= '0;
                            r_state  <= S_EMPTY;
                        end
                    end else begin
                        r_head_v <= w_head_kv;
                        if (w_accept) begin
                            r_skid_v   <= bus.in_valid;
                            r_skid_d   <= bus.in_data;
                            r_state    <= S_FULL;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so nothing can be accepted alongside the skid move.
                    if (w_head_gone) begin
                        r_head_v   <= r_skid_v;
                        r_head_d   <= r_skid_d;
                        r_skid_v   <= '0;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_head_v   <= w_head_kv;
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_head_v   <= '0;
                    r_skid_v   <= '0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_head_v;
    assign bus.out_data  = r_head_d;
    assign bus.occupancy = r_state;

    a_occ_range: assert property (@(posedge clk) disable iff (!rst)
        bus.occupancy <= 2'd2);
    a_full_not_ready: assert property (@(posedge clk) disable iff (!rst)
        (bus.occupancy == 2'd2) |-> !bus.in_ready);
    a_valid_iff_held: assert property (@(posedge clk) disable iff (!rst)
        ((|bus.out_valid) == (bus.occupancy != 2'd0)));
endmodule

// File: tb/tb_pipe_bundle_reg.sv
// Scoreboard bench: a 2-lane instance for directed scenarios and a 4-lane instance for random traffic,
// each checked every cycle against a bundle queue.
module tb_pipe_bundle_reg;
    localparam int unsigned L2 = 2;
    localparam int unsigned D2 = 64;
    localparam int unsigned L4 = 4;
    localparam int unsigned D4 = 32;

    typedef struct {
        logic [3:0]   v;
        logic [127:0] d;
    } bundle_t;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    pipe_bundle_reg_if #(.LANES(L2), .DATA_W(D2)) b2 ();
    pipe_bundle_reg_if #(.LANES(L4), .DATA_W(D4)) b4 ();

    pipe_bundle_reg #(.LANES(L2), .DATA_W(D2)) dut2 (.clk(clk), .rst(rst),  .bus(b2));
    pipe_bundle_reg #(.LANES(L4), .DATA_W(D4)) dut4 (.clk(clk), .rst(rst4), .bus(b4));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input int unsigned k);
        return {32'(k) + 32'h3000_0000, 32'(k) + 32'h2000_0000,
                32'(k) + 32'h1000_0000, 32'(k)};
    endfunction

    // Reference queues: entry 0 is the expected head, entry 1 the expected skid.
    bundle_t q2[$];
    bundle_t q4[$];
    logic    m_rdy2;
    logic    m_rdy4;
    bundle_t mb2;
    bundle_t mb4;
    logic    macc2;
    logic    macc4;

    always @(posedge clk) begin
        if (!rst) begin
            q2.delete();
            m_rdy2 = 1'b0;
        end else if (b2.flush) begin
            q2.delete();
            m_rdy2 = 1'b1;
        end else begin
            macc2 = m_rdy2 && (|b2.in_valid);
            if (q2.size() > 0) begin
                if (b2.out_ready) begin
                    void'(q2.pop_front());
                end else begin
                    mb2   = q2[0];
                    mb2.v = mb2.v & ~4'(b2.kill_mask);
                    q2[0] = mb2;
                    if (mb2.v == 4'h0) void'(q2.pop_front());
                end
            end
            if (macc2) begin
                mb2.v = 4'(b2.in_valid);
                mb2.d = b2.in_data;
                q2.push_back(mb2);
            end
            m_rdy2 = (q2.size() < 2);
        end
    end

    always @(posedge clk) begin
        if (!rst4) begin
            q4.delete();
            m_rdy4 = 1'b0;
        end else if (b4.flush) begin
            q4.delete();
            m_rdy4 = 1'b1;
        end else begin
            macc4 = m_rdy4 && (|b4.in_valid);
            if (q4.size() > 0) begin
                if (b4.out_ready) begin
                    void'(q4.pop_front());
                end else begin
                    mb4   = q4[0];
                    mb4.v = mb4.v & ~b4.kill_mask;
                    q4[0] = mb4;
                    if (mb4.v == 4'h0) void'(q4.pop_front());
                end
            end
            if (macc4) begin
                mb4.v = b4.in_valid;
                mb4.d = b4.in_data;
                q4.push_back(mb4);
            end
            m_rdy4 = (q4.size() < 2);
        end
    end

    always @(negedge clk) begin
        check("occ2", 128'(b2.occupancy), 128'(q2.size()));
        check("rdy2", 128'(b2.in_ready), 128'(m_rdy2));
        if (q2.size() > 0) begin
            check("vld2", 128'(b2.out_valid), 128'(q2[0].v));
            check("dat2", b2.out_data, q2[0].d);
        end else begin
            check("vld2_empty", 128'(b2.out_valid), 128'(0));
        end
        check("occ4", 128'(b4.occupancy), 128'(q4.size()));
        check("rdy4", 128'(b4.in_ready), 128'(m_rdy4));
        if (q4.size() > 0) begin
            check("vld4", 128'(b4.out_valid), 128'(q4[0].v));
            check("dat4", b4.out_data, q4[0].d);
        end else begin
            check("vld4_empty", 128'(b4.out_valid), 128'(0));
        end
    end

    initial begin
        rst  = 1'b0;
        rst4 = 1'b0;
        b2.flush = 1'b0; b2.kill_mask = '0; b2.in_valid = '0; b2.in_data = '0; b2.out_ready = 1'b0;
        b4.flush = 1'b0; b4.kill_mask = '0; b4.in_valid = '0; b4.in_data = '0; b4.out_ready = 1'b0;

        // reset held with a bundle offered
        b2.in_valid = 2'b11;
        b2.in_data  = pat(100);
        repeat (3) begin
            tick();
            check("rst_rdy", 128'(b2.in_ready), 128'(0));
            check("rst_vld", 128'(b2.out_valid), 128'(0));
            check("rst_occ", 128'(b2.occupancy), 128'(0));
        end
        rst = 1'b1;
        tick();
        check("rel_rdy", 128'(b2.in_ready), 128'(1));
        check("rel_occ", 128'(b2.occupancy), 128'(0));
        b2.in_valid = '0;

        // streaming at full rate
        b2.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b2.in_valid = 2'b11;
            b2.in_data  = pat(k);
            tick();
            check("stream_occ", 128'(b2.occupancy), 128'(1));
            check("stream_dat", b2.out_data, pat(k));
        end
        b2.in_valid = '0;
        tick();
        check("stream_drain", 128'(b2.occupancy), 128'(0));

        // back-pressure
        b2.out_ready = 1'b0;
        b2.in_valid  = 2'b11;
        b2.in_data   = pat(10);
        tick();
        b2.in_data   = pat(11);
        tick();
        check("bp_occ", 128'(b2.occupancy), 128'(2));
        check("bp_rdy", 128'(b2.in_ready), 128'(0));
        check("bp_head", b2.out_data, pat(10));
        b2.in_data   = pat(12);
        tick();
        check("bp_hold", b2.out_data, pat(10));
        b2.out_ready = 1'b1;
        tick();
        check("bp_b", b2.out_data, pat(11));
        check("bp_b_occ", 128'(b2.occupancy), 128'(1));
        tick();
        check("bp_c", b2.out_data, pat(12));
        b2.in_valid  = '0;
        tick();
        check("bp_done", 128'(b2.occupancy), 128'(0));

        // per-lane kill of the head, then full kill with a skid behind it
        b2.out_ready = 1'b0;
        b2.in_valid  = 2'b11;
        b2.in_data   = pat(20);
        tick();
        b2.in_valid  = '0;
        b2.kill_mask = 2'b10;
        tick();
        check("kill_vld", 128'(b2.out_valid), 128'(2'b01));
        check("kill_dat", b2.out_data, pat(20));
        b2.kill_mask = '0;
        b2.in_valid  = 2'b11;
        b2.in_data   = pat(21);
        tick();
        check("kill_full", 128'(b2.occupancy), 128'(2));
        b2.in_valid  = '0;
        b2.kill_mask = 2'b11;
        tick();
        check("kill_occ", 128'(b2.occupancy), 128'(1));
        check("kill_skid", b2.out_data, pat(21));
        check("kill_skid_v", 128'(b2.out_valid), 128'(2'b11));
        b2.kill_mask = '0;
        b2.out_ready = 1'b1;
        tick();

        // flush from full with an offered bundle, then from one with an accepted bundle
        b2.out_ready = 1'b0;
        b2.in_valid  = 2'b11;
        b2.in_data   = pat(30);
        tick();
        b2.in_data   = pat(31);
        tick();
        b2.in_data   = pat(32);
        b2.flush     = 1'b1;
        tick();
        b2.flush     = 1'b0;
        b2.in_valid  = '0;
        check("fl_occ", 128'(b2.occupancy), 128'(0));
        check("fl_vld", 128'(b2.out_valid), 128'(0));
        check("fl_rdy", 128'(b2.in_ready), 128'(1));
        repeat (2) tick();
        b2.in_valid  = 2'b11;
        b2.in_data   = pat(33);
        tick();
        b2.in_data   = pat(34);
        b2.flush     = 1'b1;
        tick();
        b2.flush     = 1'b0;
        b2.in_valid  = '0;
        check("fl1_occ", 128'(b2.occupancy), 128'(0));
        tick();

        // partial and empty bundles
        b2.out_ready = 1'b1;
        b2.in_valid  = 2'b01;
        b2.in_data   = pat(40);
        tick();
        check("part_vld", 128'(b2.out_valid), 128'(2'b01));
        check("part_dat", b2.out_data, pat(40));
        b2.in_valid  = 2'b00;
        b2.in_data   = pat(41);
        tick();
        check("empty_bundle", 128'(b2.occupancy), 128'(0));
        b2.in_valid  = 2'b10;
        b2.in_data   = pat(42);
        tick();
        check("part_hi", 128'(b2.out_valid), 128'(2'b10));
        b2.in_valid  = '0;
        tick();

        // reset while full
        b2.out_ready = 1'b0;
        b2.in_valid  = 2'b11;
        b2.in_data   = pat(50);
        tick();
        b2.in_data   = pat(51);
        tick();
        rst          = 1'b0;
        b2.in_valid  = '0;
        tick();
        check("mrst_occ", 128'(b2.occupancy), 128'(0));
        check("mrst_rdy", 128'(b2.in_ready), 128'(0));
        rst = 1'b1;
        tick();
        check("mrst_rel", 128'(b2.in_ready), 128'(1));

        // random traffic on the 4-lane instance
        repeat (2) tick();
        rst4 = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            b4.in_valid  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            b4.in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            b4.out_ready = ($urandom_range(0, 9) < 6);
            b4.kill_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            b4.flush     = ($urandom_range(0, 99) == 0);
            rst4         = ($urandom_range(0, 499) != 0);
            tick();
        end
        b4.in_valid  = '0;
        b4.kill_mask = '0;
        b4.flush     = 1'b0;
        b4.out_ready = 1'b1;
        rst4         = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
